p4_user_extern_initiator: RTL and testbench

P4_USER_EXTERN_INITIATOR -- requirements
Module: p4_user_extern_initiator

---
 rtl/p4_user_extern_initiator.sv | 117 +++++++++++
 tb/tb_p4_user_extern_initiator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_user_extern_initiator.sv
`timescale 1ns/1ps
// Credit-limited request initiator for a P4 user extern: registered issue path,
// in-order response FIFO (first-word-fall-through) and a response timeout.
module p4_user_extern_initiator #(
  parameter int unsigned REQ_DATA_BITS   = 160,
  parameter int unsigned RESP_DATA_BITS  = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                                     clk,
  input  logic                                     sresetn,
  input  logic [REQ_DATA_BITS-1:0]                 req_tdata,
  input  logic                                     req_tvalid,
  output logic                                     req_tready,
  output logic [REQ_DATA_BITS-1:0]                 ue_out_data,
  output logic                                     ue_out_valid,
  input  logic [RESP_DATA_BITS-1:0]                ue_in_data,
  input  logic                                     ue_in_valid,
  output logic [RESP_DATA_BITS-1:0]                resp_tdata,
  output logic                                     resp_tvalid,
  input  logic                                     resp_tready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
  output logic                                     timeout_err,
  output logic                                     spurious_err
);

  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW    = OW + 1;
  localparam int unsigned PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned DEPTH = 2 ** PW;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES);

  logic                      active_q;
  logic [OW-1:0]             out_q, out_d;
  logic [OW-1:0]             cnt_q, cnt_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic [RESP_DATA_BITS-1:0] mem_q [DEPTH];
  logic                      hs, acc, spur, rd, tmo;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover both unanswered requests and responses still parked in the FIFO.
  assign req_tready  = active_q && ((SW'(out_q) + SW'(cnt_q)) < SW'(MAX_OUTSTANDING));
  assign resp_tvalid = (cnt_q != '0);
  assign resp_tdata  = mem_q[rd_ptr_q];
  assign outstanding = out_q;

  // Next-state computation
  always_comb begin
    hs       = req_tvalid && req_tready;
    acc      = ue_in_valid && (out_q != '0);
    spur     = ue_in_valid && (out_q == '0);
    rd       = resp_tvalid && resp_tready;
    tmo      = (out_q != '0) && !acc && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    out_d    = out_q + OW'(hs) - OW'(acc);
    cnt_d    = cnt_q + OW'(acc) - OW'(rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tcnt_d   = tcnt_q + TW'(1);
    if (tmo) begin
      out_d = hs ? OW'(1) : '0;
    end
    if (tmo || acc || (out_q == '0)) begin
      tcnt_d = '0;
    end
    if (acc) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (rd) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      active_q     <= 1'b0;
      out_q        <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tcnt_q       <= '0;
      ue_out_valid <= 1'b0;
      ue_out_data  <= '0;
      timeout_err  <= 1'b0;
      spurious_err <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      active_q     <= 1'b1;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tcnt_q       <= tcnt_d;
      ue_out_valid <= hs;
      timeout_err  <= tmo;
      spurious_err <= spur;
      if (hs) begin
        ue_out_data <= req_tdata;
      end
      if (acc) begin
        mem_q[wr_ptr_q] <= ue_in_data;
      end
    end
  end

  // A write into a full FIFO with no simultaneous read would lose a response.
  fifo_overflow_a : assert property (@(posedge clk) disable iff (!sresetn)
    !(acc && !rd && (cnt_q == OW'(MAX_OUTSTANDING))));

endmodule

// File: tb/tb_p4_user_extern_initiator.sv
`timescale 1ns/1ps
// Bench for p4_user_extern_initiator: directed scenarios plus a randomized run
// against a queue-based transaction model.
module tb_p4_user_extern_initiator;

  localparam int unsigned RQ   = 160;
  localparam int unsigned RS   = 16;
  localparam int unsigned MAXO = 4;
  localparam int unsigned TMO  = 16;
  localparam int unsigned OWB  = $clog2(MAXO + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           sresetn;
  logic [RQ-1:0]  req_tdata;
  logic           req_tvalid, req_tready;
  logic [RQ-1:0]  ue_out_data;
  logic           ue_out_valid;
  logic [RS-1:0]  ue_in_data;
  logic           ue_in_valid;
  logic [RS-1:0]  resp_tdata;
  logic           resp_tvalid, resp_tready;
  logic [OWB-1:0] outstanding;
  logic           timeout_err, spurious_err;

  logic [31:0] req_tdata_1, ue_out_data_1;
  logic        req_tvalid_1, req_tready_1, ue_out_valid_1;
  logic [7:0]  ue_in_data_1, resp_tdata_1;
  logic        ue_in_valid_1, resp_tvalid_1, resp_tready_1;
  logic [0:0]  outstanding_1;
  logic        timeout_err_1, spurious_err_1;

  int checks   = 0;
  int failures = 0;

  p4_user_extern_initiator #(
    .REQ_DATA_BITS(RQ), .RESP_DATA_BITS(RS),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .clk(clk), .sresetn(sresetn),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .ue_out_data(ue_out_data), .ue_out_valid(ue_out_valid),
    .ue_in_data(ue_in_data), .ue_in_valid(ue_in_valid),
    .resp_tdata(resp_tdata), .resp_tvalid(resp_tvalid), .resp_tready(resp_tready),
    .outstanding(outstanding), .timeout_err(timeout_err), .spurious_err(spurious_err)
  );

  p4_user_extern_initiator #(
    .REQ_DATA_BITS(32), .RESP_DATA_BITS(8),
    .MAX_OUTSTANDING(1), .TIMEOUT_CYCLES(8)
  ) u_dut1 (
    .clk(clk), .sresetn(sresetn),
    .req_tdata(req_tdata_1), .req_tvalid(req_tvalid_1), .req_tready(req_tready_1),
    .ue_out_data(ue_out_data_1), .ue_out_valid(ue_out_valid_1),
    .ue_in_data(ue_in_data_1), .ue_in_valid(ue_in_valid_1),
    .resp_tdata(resp_tdata_1), .resp_tvalid(resp_tvalid_1), .resp_tready(resp_tready_1),
    .outstanding(outstanding_1), .timeout_err(timeout_err_1), .spurious_err(spurious_err_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_tvalid = 1'b0; req_tdata = '0; ue_in_valid = 1'b0; ue_in_data = '0; resp_tready = 1'b0;
    req_tvalid_1 = 1'b0; req_tdata_1 = '0; ue_in_valid_1 = 1'b0; ue_in_data_1 = '0; resp_tready_1 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    sresetn = 1'b0;
    tick(); tick();
    sresetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    sresetn = 1'b0; req_tvalid = 1'b1; req_tdata = {5{32'hDEADBEEF}};
    ue_in_valid = 1'b1; ue_in_data = 16'h7777; resp_tready = 1'b1;
    tick(); tick();
    checks++; if (req_tready !== 1'b0) begin failures++; $display("FAIL reset_req_tready: got %b want 0", req_tready); end
    checks++; if (ue_out_valid !== 1'b0) begin failures++; $display("FAIL reset_ue_out_valid: got %b want 0", ue_out_valid); end
    checks++; if (ue_out_data !== '0) begin failures++; $display("FAIL reset_ue_out_data: got %h want 0", ue_out_data); end
    checks++; if (resp_tvalid !== 1'b0 || resp_tdata !== '0) begin failures++; $display("FAIL reset_resp: got valid=%b data=%h want 0/0", resp_tvalid, resp_tdata); end
    checks++; if (outstanding !== '0) begin failures++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (timeout_err !== 1'b0 || spurious_err !== 1'b0) begin failures++; $display("FAIL reset_errs: got tmo=%b spur=%b want 0/0", timeout_err, spurious_err); end
    idle_inputs();
    sresetn = 1'b1;
    checks++; if (req_tready !== 1'b0) begin failures++; $display("FAIL release_ready_early: got %b want 0", req_tready); end
    tick();
    checks++; if (req_tready !== 1'b1) begin failures++; $display("FAIL release_ready: got %b want 1", req_tready); end
  endtask

  task automatic test_single();
    logic [RQ-1:0] pat;
    pat = {20{8'hA5}};
    do_reset();
    req_tvalid = 1'b1; req_tdata = pat;
    tick();
    req_tvalid = 1'b0; req_tdata = '0;
    checks++; if (ue_out_valid !== 1'b1 || ue_out_data !== pat) begin failures++; $display("FAIL single_issue: got valid=%b data=%h want 1/%h", ue_out_valid, ue_out_data, pat); end
    checks++; if (outstanding !== OWB'(1)) begin failures++; $display("FAIL single_out1: got %0d want 1", outstanding); end
    tick();
    checks++; if (ue_out_valid !== 1'b0 || ue_out_data !== pat) begin failures++; $display("FAIL single_hold: got valid=%b data=%h want 0/%h", ue_out_valid, ue_out_data, pat); end
    tick(); tick(); tick();
    ue_in_valid = 1'b1; ue_in_data = 16'h1234;
    tick();
    ue_in_valid = 1'b0;
    checks++; if (resp_tvalid !== 1'b1 || resp_tdata !== 16'h1234) begin failures++; $display("FAIL single_resp: got valid=%b data=%h want 1/1234", resp_tvalid, resp_tdata); end
    checks++; if (outstanding !== '0 || spurious_err !== 1'b0) begin failures++; $display("FAIL single_out0: got out=%0d spur=%b want 0/0", outstanding, spurious_err); end
    resp_tready = 1'b1;
    tick();
    resp_tready = 1'b0;
    checks++; if (resp_tvalid !== 1'b0) begin failures++; $display("FAIL single_drain: got %b want 0", resp_tvalid); end
  endtask

  task automatic test_credit_limit();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      req_tvalid = 1'b1; req_tdata = RQ'(i + 1);
      tick();
      if (ue_out_valid === 1'b1) pulses++;
      if (i == 2) begin
        checks++; if (req_tready !== 1'b1) begin failures++; $display("FAIL credit_ready_after3: got %b want 1", req_tready); end
      end
      if (i == 3) begin
        checks++; if (req_tready !== 1'b0) begin failures++; $display("FAIL credit_ready_after4: got %b want 0", req_tready); end
      end
    end
    req_tvalid = 1'b0;
    tick();
    if (ue_out_valid === 1'b1) pulses++;
    checks++; if (pulses != 4) begin failures++; $display("FAIL credit_pulses: got %0d want 4", pulses); end
    checks++; if (outstanding !== OWB'(4)) begin failures++; $display("FAIL credit_outstanding: got %0d want 4", outstanding); end
    checks++; if (ue_out_data !== RQ'(4)) begin failures++; $display("FAIL credit_last_data: got %h want 4", ue_out_data); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_tvalid = 1'b1; req_tdata = RQ'(32'hC0DE0000 + i);
      tick();
    end
    req_tvalid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ue_in_valid = 1'b1; ue_in_data = RS'(k);
      tick();
    end
    ue_in_valid = 1'b0;
    checks++; if (req_tready !== 1'b0 || outstanding !== '0) begin failures++; $display("FAIL bp_full: got ready=%b out=%0d want 0/0", req_tready, outstanding); end
    tick(); tick();
    checks++; if (resp_tvalid !== 1'b1 || resp_tdata !== RS'(1)) begin failures++; $display("FAIL bp_stable: got valid=%b data=%h want 1/1", resp_tvalid, resp_tdata); end
    resp_tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (resp_tvalid !== 1'b1 || resp_tdata !== RS'(k)) begin failures++; $display("FAIL bp_order%0d: got valid=%b data=%h want 1/%0h", k, resp_tvalid, resp_tdata, k); end
      tick();
    end
    resp_tready = 1'b0;
    checks++; if (resp_tvalid !== 1'b0 || req_tready !== 1'b1) begin failures++; $display("FAIL bp_empty: got valid=%b ready=%b want 0/1", resp_tvalid, req_tready); end
  endtask

  task automatic test_timeout();
    int cyc, seen;
    do_reset();
    req_tvalid = 1'b1; req_tdata = RQ'(32'h11);
    tick();
    req_tdata = RQ'(32'h22);
    tick();
    req_tvalid = 1'b0;
    cyc = 2;
    seen = -1;
    while (seen < 0 && cyc < 40) begin
      if (timeout_err === 1'b1) seen = cyc;
      else begin tick(); cyc++; end
    end
    checks++; if (seen != 17) begin failures++; $display("FAIL timeout_cycle: got %0d want 17", seen); end
    checks++; if (outstanding !== '0) begin failures++; $display("FAIL timeout_out: got %0d want 0", outstanding); end
    tick();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width: got %b want 0", timeout_err); end
    ue_in_valid = 1'b1; ue_in_data = 16'hABCD;
    tick();
    ue_in_valid = 1'b0;
    checks++; if (spurious_err !== 1'b1 || resp_tvalid !== 1'b0) begin failures++; $display("FAIL timeout_late: got spur=%b valid=%b want 1/0", spurious_err, resp_tvalid); end
    tick();
    checks++; if (spurious_err !== 1'b0 || resp_tvalid !== 1'b0) begin failures++; $display("FAIL timeout_late_after: got spur=%b valid=%b want 0/0", spurious_err, resp_tvalid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_tvalid = 1'b1;
    tick(); tick();
    ue_in_valid = 1'b1; ue_in_data = 16'hBEEF; resp_tready = 1'b0;
    tick();
    idle_inputs();
    checks++; if (outstanding !== OWB'(2) || ue_out_valid !== 1'b1) begin failures++; $display("FAIL simul_out: got out=%0d uev=%b want 2/1", outstanding, ue_out_valid); end
    checks++; if (resp_tvalid !== 1'b1 || resp_tdata !== 16'hBEEF) begin failures++; $display("FAIL simul_resp: got valid=%b data=%h want 1/beef", resp_tvalid, resp_tdata); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_tvalid = 1'b1; req_tdata = {5{32'h5A5A0000 + 32'(i)}};
      tick();
    end
    req_tvalid = 1'b0;
    ue_in_valid = 1'b1; ue_in_data = 16'h0055;
    tick();
    ue_in_valid = 1'b0;
    checks++; if (outstanding !== OWB'(3) || resp_tvalid !== 1'b1) begin failures++; $display("FAIL mid_setup: got out=%0d valid=%b want 3/1", outstanding, resp_tvalid); end
    sresetn = 1'b0;
    tick();
    checks++; if (req_tready !== 1'b0 || ue_out_valid !== 1'b0 || ue_out_data !== '0) begin failures++; $display("FAIL mid_rst_issue: got rdy=%b uev=%b data=%h want 0/0/0", req_tready, ue_out_valid, ue_out_data); end
    checks++; if (resp_tvalid !== 1'b0 || resp_tdata !== '0 || outstanding !== '0) begin failures++; $display("FAIL mid_rst_resp: got valid=%b data=%h out=%0d want 0/0/0", resp_tvalid, resp_tdata, outstanding); end
    sresetn = 1'b1;
    tick();
    checks++; if (req_tready !== 1'b1 || resp_tvalid !== 1'b0) begin failures++; $display("FAIL mid_release: got rdy=%b valid=%b want 1/0", req_tready, resp_tvalid); end
    ue_in_valid = 1'b1; ue_in_data = 16'h0066;
    tick();
    ue_in_valid = 1'b0;
    checks++; if (spurious_err !== 1'b1 || resp_tvalid !== 1'b0) begin failures++; $display("FAIL mid_spurious: got spur=%b valid=%b want 1/0", spurious_err, resp_tvalid); end
  endtask

  task automatic test_depth1();
    logic [31:0] d;
    logic [7:0]  r;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = $urandom(); r = 8'($urandom());
      checks++; if (req_tready_1 !== 1'b1) begin failures++; $display("FAIL d1_ready%0d: got %b want 1", i, req_tready_1); end
      req_tvalid_1 = 1'b1; req_tdata_1 = d;
      tick();
      req_tvalid_1 = 1'b0;
      checks++; if (ue_out_valid_1 !== 1'b1 || ue_out_data_1 !== d || req_tready_1 !== 1'b0 || outstanding_1 !== 1'b1) begin failures++; $display("FAIL d1_issue%0d: got v=%b d=%h rdy=%b out=%b want 1/%h/0/1", i, ue_out_valid_1, ue_out_data_1, req_tready_1, outstanding_1, d); end
      ue_in_valid_1 = 1'b1; ue_in_data_1 = r;
      tick();
      ue_in_valid_1 = 1'b0;
      checks++; if (resp_tvalid_1 !== 1'b1 || resp_tdata_1 !== r || req_tready_1 !== 1'b0 || outstanding_1 !== 1'b0) begin failures++; $display("FAIL d1_resp%0d: got v=%b d=%h rdy=%b out=%b want 1/%h/0/0", i, resp_tvalid_1, resp_tdata_1, req_tready_1, outstanding_1, r); end
      resp_tready_1 = 1'b1;
      tick();
      resp_tready_1 = 1'b0;
      checks++; if (resp_tvalid_1 !== 1'b0 || spurious_err_1 !== 1'b0 || timeout_err_1 !== 1'b0) begin failures++; $display("FAIL d1_drain%0d: got v=%b spur=%b tmo=%b want 0/0/0", i, resp_tvalid_1, spurious_err_1, timeout_err_1); end
    end
  endtask

  // Randomized traffic checked against a transaction model: a count of unanswered
  // requests, a queue of undelivered responses and a count of cycles spent waiting.
  task automatic test_random();
    int unsigned m_out, m_wait;
    logic [RS-1:0] m_q[$];
    logic [RQ-1:0] e_data;
    bit e_valid, e_tmo, e_spur, can_issue, issued, answered, expired;
    int n_tmo;
    do_reset();
    m_out = 0; m_wait = 0; m_q.delete();
    e_data = '0; e_valid = 1'b0; e_tmo = 1'b0; e_spur = 1'b0; n_tmo = 0;
    for (int i = 0; i < 800; i++) begin
      checks++; if (req_tready !== (m_out + m_q.size() < MAXO)) begin failures++; $display("FAIL rnd_ready@%0d: got %b want %b", i, req_tready, (m_out + m_q.size() < MAXO)); end
      checks++; if (ue_out_valid !== e_valid || ue_out_data !== e_data) begin failures++; $display("FAIL rnd_issue@%0d: got v=%b d=%h want %b/%h", i, ue_out_valid, ue_out_data, e_valid, e_data); end
      checks++; if (outstanding !== OWB'(m_out)) begin failures++; $display("FAIL rnd_out@%0d: got %0d want %0d", i, outstanding, m_out); end
      checks++; if (resp_tvalid !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_rvalid@%0d: got %b want %b", i, resp_tvalid, (m_q.size() != 0)); end
      if (m_q.size() != 0) begin
        checks++; if (resp_tdata !== m_q[0]) begin failures++; $display("FAIL rnd_rdata@%0d: got %h want %h", i, resp_tdata, m_q[0]); end
      end
      checks++; if (timeout_err !== e_tmo || spurious_err !== e_spur) begin failures++; $display("FAIL rnd_errs@%0d: got tmo=%b spur=%b want %b/%b", i, timeout_err, spurious_err, e_tmo, e_spur); end

      req_tvalid  = ($urandom_range(99) < 60);
      req_tdata   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      ue_in_valid = ($urandom_range(99) < ((i < 400) ? 40 : 6));
      ue_in_data  = RS'($urandom());
      resp_tready = ($urandom_range(99) < 60);

      can_issue = (m_out + m_q.size() < MAXO);
      issued    = req_tvalid && can_issue;
      answered  = ue_in_valid && (m_out > 0);
      expired   = (m_out > 0) && !answered && (m_wait == TMO - 1);
      e_spur    = ue_in_valid && (m_out == 0);
      e_tmo     = expired;
      e_valid   = issued;
      if (issued) e_data = req_tdata;
      if (resp_tready && m_q.size() != 0) void'(m_q.pop_front());
      if (answered) m_q.push_back(ue_in_data);
      m_wait = (expired || answered || m_out == 0) ? 0 : m_wait + 1;
      if (expired) m_out = issued ? 1 : 0;
      else m_out = m_out + (issued ? 1 : 0) - (answered ? 1 : 0);
      if (expired) n_tmo++;
      tick();
    end
    idle_inputs();
    checks++; if (n_tmo == 0) begin failures++; $display("FAIL rnd_no_timeouts: got %0d timeouts want >0", n_tmo); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    sresetn = 1'b0;
    test_reset();
    test_single();
    test_credit_limit();
    test_backpressure();
    test_timeout();
    test_simultaneous();
    test_reset_midflight();
    test_depth1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
